m_cp0: RTL and testbench
========================

# m_cp0

Coprocessor-0 for the pipelined MIPS core. It sits in the M stage, directly downstream of the E-stage exception detector. It consumes the exception flag and code carried down the pipeline, plus the six hardware interrupt lines. It holds SR, Cause, EPC and PRId, raises the flush/redirect request to the pipeline controller, and serves `mfc0`/`mtc0`/`eret`.

## Interface
- `PRID`, default 32'h0000_0290: constant value returned for register 15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low. `reset==0` at a rising edge clears all state.
- `A1` input 5: `mfc0` read register number.
- `A2` input 5: `mtc0` write register number.
- `DIn` input 32: `mtc0` write data (GRF[rt]).
- `WE` input 1: `mtc0` in M stage.
- `EXLClr` input 1: `eret` in M stage.
- `PC` input 32: PC of the instruction currently in M.
- `BD` input 1: instruction in M is in a branch delay slot.
- `ExcGot` input 1: an exception was flagged for the instruction in M.
- `ExcCode` input 5: code accompanying `ExcGot`, e.g. Ov=12, AdEL=4, AdES=5, RI=10.
- `HWInt` input 6: external interrupt lines, level-sensitive.
- `IntReq` output 1: take interrupt/exception now; flush the pipeline and fetch from the handler at 0x4180.
- `EPC` output 32: current EPC register, the `eret` target.
- `DOut` output 32: `mfc0` read data.

## Operation
- Register 12, SR: IM=SR[15:10], EXL=SR[1], IE=SR[0]. All other bits read 0.
- Register 13, Cause: BD=Cause[31], IP=Cause[15:10], ExcCode=Cause[6:2]. All other bits read 0.
- Register 14, EPC: 32 bits, always word aligned.
- Register 15, PRId: reads `PRID`.
- Any other `A1` value reads 0.
- Interrupt pending: IntPend = |(HWInt & IM) & IE & !EXL.
- Exception pending: ExcPend = ExcGot & !EXL.
- IntReq = (IntPend | ExcPend) & reset. It is forced to 0 while `reset==0`.
- Priority: an interrupt wins over a simultaneous exception, and the recorded ExcCode is then 0 (Int).
- On an edge with IntReq=1:
  - EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= IntPend ? 0 : ExcCode.
  - EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- IP <= HWInt on every non-reset edge, regardless of IntReq.
- `mtc0` (WE=1, IntReq=0):
  - A2=12 writes SR fields IM, EXL, IE from the matching `DIn` bits.
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - Writes to 13, 15 and all other numbers are ignored.
- `eret` (EXLClr=1, IntReq=0): EXL <= 0.
- Simultaneous events:
  - IntReq=1 suppresses WE and EXLClr for that edge, because the instruction is squashed.
  - WE writing SR together with EXLClr: EXL ends at 0, and IM/IE take `DIn`.
- While EXL=1, new exceptions and interrupts are masked. ExcGot is ignored and nothing is recorded.

## Timing
- `IntReq`, `DOut` and `EPC` are combinational from current state and inputs, with zero latency in the same cycle.
- State updates are visible on outputs the cycle after the edge.
- No internal bypass: `mfc0` of a register written in the same cycle returns the old value. Hazard handling belongs to the stall unit.
- Reset (edge with `reset==0`):
  - SR=0, Cause=0, EPC=0.
  - Resulting outputs: IntReq=0, EPC=0, DOut=0 for A1=12/13/14, PRID for A1=15.
- Reset mid-handler (EXL=1): EXL is cleared and the pending EPC is lost, as required.
- EPC arithmetic is modulo 2^32. PC=0 with BD=1 yields 32'hFFFF_FFFC.

## Test plan
- Reset, then read A1=12/13/14/15: expect 0, 0, 0, 32'h0000_0290, and IntReq=0 even with ExcGot=1 during reset.
- Exception recording: ExcGot=1, ExcCode=12, PC=32'h0000_3010, BD=0. Expect IntReq=1 that cycle; after the edge, Cause=32'h0000_0030, EPC=32'h0000_3010, SR.EXL=1. A second ExcGot pulse then gives IntReq=0.
- Delay-slot exception: BD=1, PC=32'h0000_3014, ExcCode=4. Expect EPC=32'h0000_3010 and Cause=32'h8000_0010.
- Interrupt masking and priority:
  - `mtc0` SR=32'h0000_0401, then HWInt=6'b000001 together with ExcGot=1, ExcCode=5.
  - Expect IntReq=1 and Cause.ExcCode=0 after the edge.
  - With IM=0 and the same inputs, expect only the exception to be taken, with code 5.
- `eret` after a handler: EXLClr=1. Expect EXL=0 next cycle and EPC unchanged. With EXLClr=1 and IntReq=1 in the same cycle, expect EXL to stay 1.
- `mtc0` behaviour:
  - WE=1, A2=14, DIn=32'h0000_3007: expect EPC=32'h0000_3004.
  - A2=13: no change to Cause.
  - WE=1 with IntReq=1: the write is dropped.

Source files
------------

// File: rtl/m_cp0.sv
// m_cp0: coprocessor 0 for the M stage. Holds SR, Cause, EPC and PRId,
// raises the flush/redirect request (IntReq) and serves mfc0/mtc0/eret.
// Handshake note: there is no valid/ready pairing here. Every input is
// qualified by the pipeline each cycle. IntReq is a one-cycle combinational
// request, and the pipeline controller acts on it at the same rising edge
// where this block records the exception.
module m_cp0 #(
  parameter logic [31:0] PRID = 32'h0000_0290
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic        ExcGot,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  // EPC, kept word aligned
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_word;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // Request logic: interrupts and exceptions are both masked while EXL is set.
  always_comb begin
    int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_pend = ExcGot & ~exl_q;
    IntReq   = (int_pend | exc_pend) & reset;
    pc_word  = {PC[31:2], 2'b00};
  end

  // Next state. A taken request squashes the M instruction, so its mtc0/eret is dropped.
  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ip_d   = HWInt;
    code_d = code_q;
    epc_d  = epc_q;
    if (IntReq) begin
      exl_d  = 1'b1;
      bd_d   = BD;
      code_d = int_pend ? 5'd0 : ExcCode;
      epc_d  = BD ? (pc_word - 32'd4) : pc_word;
    end else begin
      if (WE && (A2 == REG_SR)) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (WE && (A2 == REG_EPC)) begin
        epc_d = {DIn[31:2], 2'b00};
      end
      // eret is applied last, so EXL clears even when SR is written in the same cycle.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  // mfc0 read mux. There is no bypass, so this always returns the current state.
  always_comb begin
    sr_val    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    cause_val = {bd_q, 15'h0000, ip_q, 3'b000, code_q, 2'b00};
    EPC       = epc_q;
    case (A1)
      REG_SR:    DOut = sr_val;
      REG_CAUSE: DOut = cause_val;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_m_cp0.sv
// Directed testbench for m_cp0 with hand-computed expected values.
module tb_m_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic [31:0] PC;
  logic        BD;
  logic        ExcGot;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int n_checks = 0;
  int n_errors = 0;

  m_cp0 #(.PRID(32'h0000_0290)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .EXLClr(EXLClr), .PC(PC), .BD(BD), .ExcGot(ExcGot), .ExcCode(ExcCode),
    .HWInt(HWInt), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking task
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; EXLClr = 1'b0; ExcGot = 1'b0; ExcCode = 5'd0;
    BD = 1'b0; PC = 32'h0; A2 = 5'd0; DIn = 32'h0; HWInt = 6'd0;
  endtask

  task automatic rd(input logic [4:0] a);
    A1 = a;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1; A2 = a; DIn = d;
    step();
    WE = 1'b0;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
  endtask

  task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code);
    ExcGot = 1'b1; PC = pc; BD = bd; ExcCode = code;
    #1;
  endtask

  initial begin
    idle();
    A1 = 5'd12;
    reset = 1'b0;
    // IntReq is held low during reset, even with an exception flagged
    exc(32'h0000_3000, 1'b0, 5'd12);
    check_eq("intreq_in_reset", {31'h0, IntReq}, 32'h0);
    step();
    step();
    reset = 1'b1;
    idle();
    rd(5'd12); check_eq("rst_sr", DOut, 32'h0);
    rd(5'd13); check_eq("rst_cause", DOut, 32'h0);
    rd(5'd14); check_eq("rst_epc", DOut, 32'h0);
    rd(5'd15); check_eq("rst_prid", DOut, 32'h0000_0290);
    rd(5'd3);  check_eq("rd_other", DOut, 32'h0);
    check_eq("rst_intreq", {31'h0, IntReq}, 32'h0);
    check_eq("rst_epc_out", EPC, 32'h0);

    // exception recording
    exc(32'h0000_3010, 1'b0, 5'd12);
    check_eq("exc_intreq", {31'h0, IntReq}, 32'h1);
    step();
    idle();
    rd(5'd13); check_eq("exc_cause", DOut, 32'h0000_0030);
    check_eq("exc_epc", EPC, 32'h0000_3010);
    rd(5'd12); check_eq("exc_sr", DOut, 32'h0000_0002);
    exc(32'h0000_3050, 1'b0, 5'd10);
    check_eq("exl_masks_exc", {31'h0, IntReq}, 32'h0);
    step();
    idle();
    rd(5'd13); check_eq("exl_no_record", DOut, 32'h0000_0030);
    check_eq("exl_epc_kept", EPC, 32'h0000_3010);

    // eret
    eret();
    rd(5'd12); check_eq("eret_sr", DOut, 32'h0);
    check_eq("eret_epc", EPC, 32'h0000_3010);

    // delay slot exception
    exc(32'h0000_3014, 1'b1, 5'd4);
    step();
    idle();
    check_eq("bd_epc", EPC, 32'h0000_3010);
    rd(5'd13); check_eq("bd_cause", DOut, 32'h8000_0010);
    eret();

    // interrupt priority over exception
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12); check_eq("mtc0_sr", DOut, 32'h0000_0401);
    HWInt = 6'b000001;
    exc(32'h0000_3020, 1'b0, 5'd5);
    check_eq("int_intreq", {31'h0, IntReq}, 32'h1);
    step();
    idle();
    rd(5'd13); check_eq("int_cause", DOut, 32'h0000_0400);
    check_eq("int_epc", EPC, 32'h0000_3020);
    rd(5'd12); check_eq("int_sr", DOut, 32'h0000_0403);
    eret();
    rd(5'd13); check_eq("ip_follows_hw", DOut, 32'h0000_0400 & 32'h0);
    rd(5'd12); check_eq("int_eret_sr", DOut, 32'h0000_0401);

    // IM=0: only the exception is taken
    mtc0(5'd12, 32'h0000_0001);
    HWInt = 6'b000001;
    exc(32'h0000_3030, 1'b0, 5'd5);
    check_eq("im0_intreq", {31'h0, IntReq}, 32'h1);
    step();
    idle();
    rd(5'd13); check_eq("im0_cause", DOut, 32'h0000_0414);
    check_eq("im0_epc", EPC, 32'h0000_3030);

    // EXL masks interrupts
    mtc0(5'd12, 32'h0000_0403);
    HWInt = 6'b000001;
    #1;
    check_eq("exl_masks_int", {31'h0, IntReq}, 32'h0);
    HWInt = 6'b000000;

    // SR write together with eret: EXL ends 0, IM/IE from DIn
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0803; EXLClr = 1'b1;
    step();
    idle();
    rd(5'd12); check_eq("sr_and_eret", DOut, 32'h0000_0801);

    // exception squashes eret and mtc0 in the same cycle
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_1234;
    exc(32'h0000_3040, 1'b0, 5'd10);
    check_eq("squash_intreq", {31'h0, IntReq}, 32'h1);
    step();
    idle();
    rd(5'd12); check_eq("squash_exl", DOut, 32'h0000_0803);
    check_eq("squash_epc", EPC, 32'h0000_3040);
    rd(5'd13); check_eq("squash_cause", DOut, 32'h0000_0028);

    // mtc0 EPC alignment, ignored writes
    mtc0(5'd14, 32'h0000_3007);
    check_eq("mtc0_epc", EPC, 32'h0000_3004);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13); check_eq("mtc0_cause_ign", DOut, 32'h0000_0028);
    mtc0(5'd15, 32'h1234_5678);
    rd(5'd15); check_eq("mtc0_prid_ign", DOut, 32'h0000_0290);

    // no bypass: a same-cycle read returns the old value
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000;
    rd(5'd14); check_eq("no_bypass_old", DOut, 32'h0000_3004);
    step();
    idle();
    rd(5'd14); check_eq("no_bypass_new", DOut, 32'h0000_5000);

    // EPC wraps modulo 2^32
    eret();
    exc(32'h0000_0000, 1'b1, 5'd12);
    step();
    idle();
    check_eq("epc_wrap", EPC, 32'hFFFF_FFFC);
    rd(5'd13); check_eq("wrap_cause", DOut, 32'h8000_0030);

    // reset mid-handler
    reset = 1'b0;
    #1;
    exc(32'h0000_3060, 1'b0, 5'd4);
    check_eq("midrst_intreq", {31'h0, IntReq}, 32'h0);
    step();
    reset = 1'b1;
    idle();
    rd(5'd12); check_eq("midrst_sr", DOut, 32'h0);
    rd(5'd13); check_eq("midrst_cause", DOut, 32'h0);
    rd(5'd14); check_eq("midrst_epc", DOut, 32'h0);
    rd(5'd15); check_eq("midrst_prid", DOut, 32'h0000_0290);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
